// File: rtl/muldiv_pkg.sv
// Shared encodings and types for the iterative M-extension multiply/divide unit.
package muldiv_pkg;
    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    localparam int W_BIT = 3;

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] OPC_OP32 = 7'b0111011;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/muldiv_if.sv
// Issue/result handshake bundle between the pipeline and the muldiv unit.
interface muldiv_if #(parameter int XLEN = 64, parameter int TAG_W = 5);
    logic             in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [3:0]       in_op;
    logic [XLEN-1:0]  in_a, in_b, out_result;
    logic [TAG_W-1:0] in_tag, out_tag;

    modport master (output in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
                    input  in_ready, out_valid, out_result, out_tag, busy);
    modport slave  (input  in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
                    output in_ready, out_valid, out_result, out_tag, busy);
endinterface

// File: rtl/muldiv_div_core.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle after start.
module muldiv_div_core #(parameter int XLEN = 64) (
    input  logic            clk,
    input  logic            RESET,
    input  logic            start,
    input  logic            w,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] q_q, r_q, d_q, diff;
    logic [CW-1:0]   cnt_q, n_q;
    logic [XLEN:0]   rsh;
    logic            ge;

    always_comb begin
        rsh  = {r_q, q_q[XLEN-1]};
        ge   = rsh >= {1'b0, d_q};
        diff = rsh[XLEN-1:0] - d_q;
    end

    // Word ops park the 32-bit dividend in the top half so 32 steps consume it.
    always_ff @(posedge clk) begin
        if (RESET) begin
            q_q <= '0; r_q <= '0; d_q <= '0; cnt_q <= '0; n_q <= '0;
        end else if (start) begin
            q_q   <= w ? dividend << (XLEN / 2) : dividend;
            r_q   <= '0;
            d_q   <= divisor;
            cnt_q <= '0;
            n_q   <= w ? CW'(32) : CW'(XLEN);
        end else if (!done) begin
            q_q   <= {q_q[XLEN-2:0], ge};
            r_q   <= ge ? diff : rsh[XLEN-1:0];
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign done = cnt_q == n_q;
    assign quot = q_q;
    assign rem  = r_q;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M/RV32M multiply/divide unit: shift-add multiply, restoring divide, fast paths.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input logic     clk,
    input logic     RESET,
    muldiv_if.slave io
);
    localparam int CW = $clog2(XLEN) + 1;

    state_t state, state_nx;

    logic             w, is_div, a_s, b_s, sa, sb, div_z, ovf, illegal, fast, accept;
    logic             w_q, is_div_q, neg_q, rneg_q, fin_done, div_done;
    logic [2:0]       f3, f3_q;
    logic [XLEN-1:0]  a_e, b_e, mag_a, mag_b, min_v, fast_raw, fast_res;
    logic [XLEN-1:0]  ma_q, res_q, dq, dr, quot, remv, fin;
    logic [2*XLEN-1:0] acc_q, prod;
    logic [XLEN:0]    sum;
    logic [CW-1:0]    cnt_q, n_q;
    logic [TAG_W-1:0] tag_q;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    always_comb begin
        f3     = io.in_op[2:0];
        w      = io.in_op[W_BIT] && (XLEN == 64);
        is_div = f3[2];
        a_e    = io.in_a;
        b_e    = io.in_b;
        if (w) begin
            if (f3 == F_DIVU || f3 == F_REMU) begin
                a_e = XLEN'(io.in_a[31:0]);
                b_e = XLEN'(io.in_b[31:0]);
            end else begin
                a_e = sext32(io.in_a[31:0]);
                b_e = sext32(io.in_b[31:0]);
            end
        end
        a_s     = is_div ? !f3[0] : (!w && (f3 == F_MULH || f3 == F_MULHSU));
        b_s     = is_div ? !f3[0] : (!w && f3 == F_MULH);
        sa      = a_s && a_e[XLEN-1];
        sb      = b_s && b_e[XLEN-1];
        mag_a   = sa ? -a_e : a_e;
        mag_b   = sb ? -b_e : b_e;
        min_v   = w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_z   = is_div && (b_e == '0);
        ovf     = is_div && a_s && (a_e == min_v) && (b_e == '1);
        illegal = w && !is_div && (f3 != F_MUL);
        fast    = illegal || div_z || ovf;
        fast_raw = '0;
        if (div_z)    fast_raw = f3[1] ? a_e : '1;
        else if (ovf) fast_raw = f3[1] ? '0 : a_e;
        fast_res = w ? sext32(fast_raw[31:0]) : fast_raw;
        accept   = (state == IDLE) && io.in_valid && !io.flush;
    end

    // The low MULW product bits land at acc[XLEN-1 -: 32] after only 32 shift steps.
    always_comb begin
        sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, ma_q} : '0);
        prod = neg_q ? -acc_q : acc_q;
        quot = neg_q ? -dq : dq;
        remv = rneg_q ? -dr : dr;
        case (f3_q)
            F_MUL:                      fin = w_q ? sext32(acc_q[XLEN-1 -: 32]) : prod[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  fin = prod[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:              fin = w_q ? sext32(quot[31:0]) : quot;
            default:                    fin = w_q ? sext32(remv[31:0]) : remv;
        endcase
        fin_done = is_div_q ? div_done : (cnt_q == n_q);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = fast ? DONE : BUSY;
            BUSY:    if (io.flush) state_nx = IDLE;
                     else if (fin_done) state_nx = DONE;
            DONE:    if (io.flush || io.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            f3_q <= '0; w_q <= 1'b0; is_div_q <= 1'b0; neg_q <= 1'b0; rneg_q <= 1'b0;
            tag_q <= '0; ma_q <= '0; acc_q <= '0; cnt_q <= '0; n_q <= '0; res_q <= '0;
        end else if (accept) begin
            f3_q     <= f3;
            w_q      <= w;
            is_div_q <= is_div;
            neg_q    <= sa ^ sb;
            rneg_q   <= sa;
            tag_q    <= io.in_tag;
            ma_q     <= mag_a;
            acc_q    <= {{XLEN{1'b0}}, mag_b};
            cnt_q    <= '0;
            n_q      <= w ? CW'(32) : CW'(XLEN);
            res_q    <= fast_res;
        end else if (state == BUSY) begin
            if (cnt_q != n_q) begin
                cnt_q <= cnt_q + CW'(1);
                if (!is_div_q) acc_q <= {sum, acc_q[XLEN-1:1]};
            end
            if (fin_done) res_q <= fin;
        end
    end

    muldiv_div_core #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .RESET    (RESET),
        .start    (accept && is_div),
        .w        (w),
        .dividend (mag_a),
        .divisor  (mag_b),
        .done     (div_done),
        .quot     (dq),
        .rem      (dr)
    );

    assign io.in_ready   = state == IDLE;
    assign io.busy       = state != IDLE;
    assign io.out_valid  = state == DONE;
    assign io.out_result = (state == DONE) ? res_q : '0;
    assign io.out_tag    = (state == DONE) ? tag_q : '0;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=64): results, latencies, fast paths, flush, reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk, RESET, seen;
    int   n_vec, n_err, lat;

    muldiv_if #(.XLEN(64), .TAG_W(5)) io();

    muldiv_unit #(.XLEN(64), .TAG_W(5)) dut (
        .clk   (clk),
        .RESET (RESET),
        .io    (io)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag);
        io.in_valid = 1'b1; io.in_op = op; io.in_a = a; io.in_b = b; io.in_tag = tag;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        while (!io.out_valid && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic run(input string nm, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag,
                       input logic [63:0] er, input int el);
        int l;
        issue(op, a, b, tag);
        wait_valid(l);
        chk({nm, ".lat"}, 64'(l), 64'(el));
        chk({nm, ".res"}, io.out_result, er);
        chk({nm, ".tag"}, 64'(io.out_tag), 64'(tag));
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        chk({nm, ".taken"}, {61'd0, io.in_ready, io.out_valid, io.busy}, 64'b100);
    endtask

    task automatic watch_quiet(input string nm);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            seen = seen | io.out_valid;
        end
        chk(nm, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        clk = 1'b0; RESET = 1'b1; n_vec = 0; n_err = 0;
        io.in_valid = 1'b0; io.in_op = '0; io.in_a = '0; io.in_b = '0; io.in_tag = '0;
        io.flush = 1'b0; io.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 RESET = 1'b0;
        chk("rst.ctl", {61'd0, io.in_ready, io.out_valid, io.busy}, 64'b100);
        chk("rst.res", io.out_result, 64'd0);
        chk("rst.tag", 64'(io.out_tag), 64'd0);

        run("mulh_m1",  {1'b0, F_MULH},   '1, '1, 5'd1, 64'd0, 65);
        run("mul_m1",   {1'b0, F_MUL},    '1, '1, 5'd2, 64'd1, 65);
        run("mulhu",    {1'b0, F_MULHU},  '1, 64'd2, 5'd3, 64'd1, 65);
        run("mulhsu",   {1'b0, F_MULHSU}, '1, 64'd2, 5'd4, '1, 65);
        run("mulw",     {1'b1, F_MUL},    64'h7FFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        run("mulhw_il", {1'b1, F_MULH},   64'd5, 64'd6, 5'd6, 64'd0, 0);
        run("div_z",    {1'b0, F_DIV},    64'h1234, 64'd0, 5'd7, '1, 0);
        run("rem_z",    {1'b0, F_REM},    64'h1234, 64'd0, 5'd8, 64'h1234, 0);
        run("div_ovf",  {1'b0, F_DIV},    64'h8000_0000_0000_0000, '1, 5'd9, 64'h8000_0000_0000_0000, 0);
        run("rem_ovf",  {1'b0, F_REM},    64'h8000_0000_0000_0000, '1, 5'd10, 64'd0, 0);
        run("divw",     {1'b1, F_DIV},    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        run("remw",     {1'b1, F_REM},    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, '1, 33);
        run("divuw",    {1'b1, F_DIVU},   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd13, 64'h7FFF_FFFC, 33);
        run("remuw",    {1'b1, F_REMU},   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd14, 64'd1, 33);
        run("remuw_z",  {1'b1, F_REMU},   64'h8000_0000, 64'd0, 5'd15, 64'hFFFF_FFFF_8000_0000, 0);
        run("div_neg",  {1'b0, F_DIV},    64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd16, 64'hFFFF_FFFF_FFFF_FFFA, 65);
        run("rem_neg",  {1'b0, F_REM},    64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd17, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run("divu",     {1'b0, F_DIVU},   64'd100, 64'd7, 5'd18, 64'd14, 65);
        run("remu",     {1'b0, F_REMU},   64'd100, 64'd7, 5'd19, 64'd2, 65);

        // reset lands on the 10th edge after the accept edge
        issue({1'b0, F_DIVU}, 64'd100, 64'd7, 5'd20);
        repeat (9) @(posedge clk);
        #1 RESET = 1'b1;
        @(posedge clk); #1 RESET = 1'b0;
        chk("rstb.ctl", {61'd0, io.in_ready, io.out_valid, io.busy}, 64'b100);
        watch_quiet("rstb.quiet");
        run("rstb.next", {1'b0, F_DIVU}, 64'd100, 64'd7, 5'd21, 64'd14, 65);

        // backpressure with a second op offered throughout
        issue({1'b0, F_MUL}, 64'd3, 64'd5, 5'd22);
        io.in_valid = 1'b1; io.in_op = {1'b0, F_MUL}; io.in_a = 64'd9; io.in_b = 64'd9; io.in_tag = 5'd23;
        wait_valid(lat);
        chk("bp.lat", 64'(lat), 64'd65);
        for (int i = 0; i < 5; i++) begin
            chk("bp.res", io.out_result, 64'd15);
            chk("bp.tag", 64'(io.out_tag), 64'd22);
            chk("bp.rdy", {62'd0, io.in_ready, io.busy}, 64'b01);
            @(posedge clk); #1;
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0; io.in_valid = 1'b0;
        chk("bp.take", {61'd0, io.in_ready, io.out_valid, io.busy}, 64'b100);

        issue({1'b0, F_DIVU}, 64'd100, 64'd7, 5'd24);
        repeat (5) @(posedge clk);
        #1 io.flush = 1'b1;
        @(posedge clk); #1 io.flush = 1'b0;
        chk("fl_busy.ctl", {61'd0, io.in_ready, io.out_valid, io.busy}, 64'b100);
        watch_quiet("fl_busy.quiet");

        io.flush = 1'b1;
        issue({1'b0, F_MUL}, 64'd2, 64'd2, 5'd25);
        io.flush = 1'b0;
        chk("fl_idle.ctl", {61'd0, io.in_ready, io.out_valid, io.busy}, 64'b100);

        issue({1'b0, F_DIV}, 64'd7, 64'd0, 5'd26);
        chk("fl_done.val", {63'd0, io.out_valid}, 64'd1);
        io.flush = 1'b1; io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.flush = 1'b0; io.out_ready = 1'b0;
        chk("fl_done.ctl", {61'd0, io.in_ready, io.out_valid, io.busy}, 64'b100);
        chk("fl_done.res", io.out_result, 64'd0);
        chk("fl_done.tag", 64'(io.out_tag), 64'd0);

        issue({1'b0, F_REMU}, 64'd9, 64'd0, 5'd27);
        chk("fl_only.res", io.out_result, 64'd9);
        io.flush = 1'b1;
        @(posedge clk); #1 io.flush = 1'b0;
        chk("fl_only.ctl", {61'd0, io.in_ready, io.out_valid, io.busy}, 64'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
